// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, slave indices and response-side state types for the SOPC fabric.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam int SLV_RAM = 0;
    localparam int SLV_PIO = 1;
    localparam int SLV_APB = 2;

    typedef enum logic [1:0] {
        DS_IDLE = 2'b00,
        DS_ERR1 = 2'b01,
        DS_ERR2 = 2'b10
    } ds_state_e;

    // Who owns the current data phase: nobody, a decoded slave, or the default slave.
    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_SLV  = 2'b01,
        OWN_DFLT = 2'b10
    } own_kind_e;

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave: answers every accepted unmapped NONSEQ/SEQ transfer with the two-cycle AHB ERROR response.
module ahb_default_slave
    import ahb_pkg::*;
(
    input  logic hclk,
    input  logic hreset,
    input  logic sel_dflt,
    input  logic hready,
    output logic hreadyout,
    output logic hresp
);

    ds_state_e r_state;
    ds_state_e w_state_nxt;

    // sel_dflt is an address-phase qualifier; only an accepted address (hready=1) starts a response.
    always_comb begin
        w_state_nxt = DS_IDLE;
        case (r_state)
            DS_IDLE: w_state_nxt = (hready && sel_dflt) ? DS_ERR1 : DS_IDLE;
            DS_ERR1: w_state_nxt = DS_ERR2;
            DS_ERR2: w_state_nxt = (hready && sel_dflt) ? DS_ERR1 : DS_IDLE;
            default: w_state_nxt = DS_IDLE;
        endcase
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            r_state <= DS_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        hreadyout = 1'b1;
        hresp     = HRESP_OKAY;
        case (r_state)
            DS_ERR1: begin
                hreadyout = 1'b0;
                hresp     = HRESP_ERROR;
            end
            DS_ERR2: begin
                hreadyout = 1'b1;
                hresp     = HRESP_ERROR;
            end
            default: begin
                hreadyout = 1'b1;
                hresp     = HRESP_OKAY;
            end
        endcase
    end

endmodule

// File: rtl/ahb_slave_mux.sv
// AHB-Lite response mux: registers the address-phase owner and routes that slave's response to the master.
// Optional error log enabled by defining AHB_SLAVE_MUX_ERRLOG_EN.
module ahb_slave_mux
    import ahb_pkg::*;
#(
    parameter int              NSLV          = 3,
    parameter int              DW            = 32,
    parameter logic [DW-1:0]   DEFAULT_RDATA = '0
) (
    input  logic                 hclk,
    input  logic                 hreset,
    input  logic [NSLV-1:0]      hsel,
    input  logic [1:0]           htrans,
    input  logic [31:0]          haddr,
    input  logic [NSLV*DW-1:0]   hrdata_s,
    input  logic [NSLV-1:0]      hreadyout_s,
    input  logic [NSLV-1:0]      hresp_s,
    output logic [DW-1:0]        hrdata,
    output logic                 hready,
    output logic                 hresp,
    input  logic                 err_clr,
    output logic                 err_valid,
    output logic [31:0]          err_addr
);

    localparam int IW = (NSLV > 1) ? $clog2(NSLV) : 1;

    own_kind_e   r_own_kind;
    logic [IW-1:0] r_own_idx;

    own_kind_e   w_nxt_kind;
    logic [IW-1:0] w_nxt_idx;
    logic        w_xfer;
    logic        w_sel_dflt;
    logic [DW-1:0] w_hrdata;
    logic        w_hready;
    logic        w_hresp;
    logic        w_ds_hreadyout;
    logic        w_ds_hresp;

    assign w_xfer     = (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    assign w_sel_dflt = !(|hsel) && w_xfer;

    // Walk downwards so the lowest set hsel bit wins if the decoder ever asserts several.
    always_comb begin
        w_nxt_kind = OWN_NONE;
        w_nxt_idx  = '0;
        for (int i = NSLV - 1; i >= 0; i--) begin
            if (hsel[i]) begin
                w_nxt_kind = OWN_SLV;
                w_nxt_idx  = IW'(i);
            end
        end
        if (w_sel_dflt) begin
            w_nxt_kind = OWN_DFLT;
        end
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            r_own_kind <= OWN_NONE;
            r_own_idx  <= '0;
        end else if (w_hready) begin
            r_own_kind <= w_nxt_kind;
            r_own_idx  <= w_nxt_idx;
        end
    end

    ahb_default_slave u_dflt (
        .hclk      (hclk),
        .hreset    (hreset),
        .sel_dflt  (w_sel_dflt),
        .hready    (w_hready),
        .hreadyout (w_ds_hreadyout),
        .hresp     (w_ds_hresp)
    );

    // No owner means the previous address was IDLE/BUSY: zero-wait OKAY.
    always_comb begin
        w_hrdata = DEFAULT_RDATA;
        w_hready = 1'b1;
        w_hresp  = HRESP_OKAY;
        case (r_own_kind)
            OWN_SLV: begin
                for (int i = 0; i < NSLV; i++) begin
                    if (r_own_idx == IW'(i)) begin
                        w_hrdata = hrdata_s[i*DW +: DW];
                        w_hready = hreadyout_s[i];
                        w_hresp  = hresp_s[i];
                    end
                end
            end
            OWN_DFLT: begin
                w_hready = w_ds_hreadyout;
                w_hresp  = w_ds_hresp;
            end
            default: begin
                w_hrdata = DEFAULT_RDATA;
                w_hready = 1'b1;
                w_hresp  = HRESP_OKAY;
            end
        endcase
    end

    assign hrdata = w_hrdata;
    assign hready = w_hready;
    assign hresp  = w_hresp;

`ifdef AHB_SLAVE_MUX_ERRLOG_EN
    logic [31:0] r_addr_dp;
    logic [31:0] r_err_addr;
    logic        r_err_valid;

    // Address of the transfer currently in its data phase; follows the owner register.
    always_ff @(posedge hclk) begin
        if (w_hready) begin
            r_addr_dp <= haddr;
        end
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            r_err_valid <= 1'b0;
            r_err_addr  <= '0;
        end else if (w_hready && (w_hresp == HRESP_ERROR) && !r_err_valid) begin
            r_err_valid <= 1'b1;
            r_err_addr  <= r_addr_dp;
        end else if (err_clr) begin
            r_err_valid <= 1'b0;
            r_err_addr  <= '0;
        end
    end

    assign err_valid = r_err_valid;
    assign err_addr  = r_err_addr;
`else
    logic w_unused_errlog;
    assign w_unused_errlog = ^{haddr, err_clr};
    assign err_valid       = 1'b0;
    assign err_addr        = '0;
`endif

`ifndef SYNTHESIS
    a_hsel_onehot: assert property (@(posedge hclk) disable iff (hreset) w_hready |-> $onehot0(hsel))
        else $error("ahb_slave_mux: multiple hsel bits asserted: %b", hsel);
`endif

endmodule

// File: tb/tb_ahb_slave_mux.sv
// Scoreboard bench for ahb_slave_mux: stimulus queues per-cycle expected responses, a negedge monitor checks them.
module tb_ahb_slave_mux;
    import ahb_pkg::*;

    localparam logic [95:0] RDV = {32'h3333_3333, 32'h1234_5678, 32'hDEAD_BEEF};

    logic        hclk = 1'b0;
    logic        hreset;
    logic [2:0]  hsel;
    logic [1:0]  htrans;
    logic [31:0] haddr;
    logic [95:0] hrdata_s;
    logic [2:0]  hreadyout_s;
    logic [2:0]  hresp_s;
    logic [31:0] hrdata;
    logic        hready;
    logic        hresp;
    logic        err_clr;
    logic        err_valid;
    logic [31:0] err_addr;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] rd;
        logic        rdy;
        logic        rsp;
        string       nm;
    } exp_t;

    exp_t sb[$];
    exp_t e_mon;

    ahb_slave_mux dut (
        .hclk        (hclk),
        .hreset      (hreset),
        .hsel        (hsel),
        .htrans      (htrans),
        .haddr       (haddr),
        .hrdata_s    (hrdata_s),
        .hreadyout_s (hreadyout_s),
        .hresp_s     (hresp_s),
        .hrdata      (hrdata),
        .hready      (hready),
        .hresp       (hresp),
        .err_clr     (err_clr),
        .err_valid   (err_valid),
        .err_addr    (err_addr)
    );

    always #5 hclk = ~hclk;

    always @(negedge hclk) begin
        if (sb.size() > 0) begin
            e_mon = sb.pop_front();
            n_chk++;
            if (hrdata !== e_mon.rd || hready !== e_mon.rdy || hresp !== e_mon.rsp) begin
                n_err++;
                $display("FAIL %s: got hrdata=%h hready=%b hresp=%b, expected hrdata=%h hready=%b hresp=%b",
                         e_mon.nm, hrdata, hready, hresp, e_mon.rd, e_mon.rdy, e_mon.rsp);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive one cycle's address-phase and slave-response inputs and queue that cycle's expected output.
    task automatic cyc(input logic [2:0] sel, input logic [1:0] tr, input logic [31:0] ad,
                       input logic [2:0] ro, input logic [2:0] rs,
                       input logic [31:0] erd, input logic erdy, input logic ersp, input string nm);
        @(posedge hclk);
        #1;
        hsel        = sel;
        htrans      = tr;
        haddr       = ad;
        hreadyout_s = ro;
        hresp_s     = rs;
        sb.push_back('{rd: erd, rdy: erdy, rsp: ersp, nm: nm});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        hreset      = 1'b1;
        hsel        = 3'b000;
        htrans      = HTRANS_IDLE;
        haddr       = 32'h0;
        hrdata_s    = RDV;
        hreadyout_s = 3'b111;
        hresp_s     = 3'b000;
        err_clr     = 1'b0;

        repeat (2) @(posedge hclk);
        #1;
        chk("rst_hready", 32'(hready), 32'd1);
        chk("rst_hresp", 32'(hresp), 32'd0);
        chk("rst_hrdata", hrdata, 32'h0);
        chk("rst_err_valid", 32'(err_valid), 32'd0);
        chk("rst_err_addr", err_addr, 32'h0);
        hreset = 1'b0;

        // RAM read, zero wait
        cyc(3'b001, HTRANS_NONSEQ, 32'h1000_0010, 3'b111, 3'b000, 32'h0, 1'b1, 1'b0, "t1_addr");
        cyc(3'b000, HTRANS_IDLE,   32'h0,         3'b111, 3'b000, 32'hDEAD_BEEF, 1'b1, 1'b0, "t1_ram_data");

        // PIO with three wait states; RAM select during the wait must be ignored
        cyc(3'b010, HTRANS_NONSEQ, 32'h2000_0000, 3'b111, 3'b000, 32'h0, 1'b1, 1'b0, "t2_addr");
        cyc(3'b001, HTRANS_NONSEQ, 32'h1000_0000, 3'b101, 3'b000, 32'h1234_5678, 1'b0, 1'b0, "t2_wait1");
        cyc(3'b001, HTRANS_NONSEQ, 32'h1000_0000, 3'b101, 3'b000, 32'h1234_5678, 1'b0, 1'b0, "t2_wait2");
        cyc(3'b001, HTRANS_NONSEQ, 32'h1000_0000, 3'b101, 3'b000, 32'h1234_5678, 1'b0, 1'b0, "t2_wait3");
        cyc(3'b000, HTRANS_IDLE,   32'h0,         3'b111, 3'b000, 32'h1234_5678, 1'b1, 1'b0, "t2_okay");
        cyc(3'b000, HTRANS_IDLE,   32'h0,         3'b111, 3'b000, 32'h0, 1'b1, 1'b0, "t2_hsel_ignored");

        // Single unmapped NONSEQ
        cyc(3'b000, HTRANS_NONSEQ, 32'h4000_0000, 3'b111, 3'b000, 32'h0, 1'b1, 1'b0, "t3_addr");
        cyc(3'b000, HTRANS_IDLE,   32'h0,         3'b111, 3'b000, 32'h0, 1'b0, 1'b1, "t3_err1");
        cyc(3'b000, HTRANS_IDLE,   32'h0,         3'b111, 3'b000, 32'h0, 1'b1, 1'b1, "t3_err2");
        cyc(3'b000, HTRANS_IDLE,   32'h0,         3'b111, 3'b000, 32'h0, 1'b1, 1'b0, "t3_after");
`ifdef AHB_SLAVE_MUX_ERRLOG_EN
        chk("t3_err_valid", 32'(err_valid), 32'd1);
        chk("t3_err_addr", err_addr, 32'h4000_0000);
`else
        chk("t3_err_valid", 32'(err_valid), 32'd0);
        chk("t3_err_addr", err_addr, 32'h0);
`endif

        // Back-to-back unmapped, then IDLE and BUSY give zero-wait OKAY
        cyc(3'b000, HTRANS_NONSEQ, 32'h5000_0000, 3'b111, 3'b000, 32'h0, 1'b1, 1'b0, "t4_addr1");
        cyc(3'b000, HTRANS_NONSEQ, 32'h6000_0000, 3'b111, 3'b000, 32'h0, 1'b0, 1'b1, "t4_err1a");
        cyc(3'b000, HTRANS_NONSEQ, 32'h6000_0000, 3'b111, 3'b000, 32'h0, 1'b1, 1'b1, "t4_err2a");
        cyc(3'b000, HTRANS_IDLE,   32'h0,         3'b111, 3'b000, 32'h0, 1'b0, 1'b1, "t4_err1b");
        cyc(3'b000, HTRANS_IDLE,   32'h0,         3'b111, 3'b000, 32'h0, 1'b1, 1'b1, "t4_err2b");
        cyc(3'b000, HTRANS_IDLE,   32'h0,         3'b111, 3'b000, 32'h0, 1'b1, 1'b0, "t4_idle_addr");
        cyc(3'b000, HTRANS_BUSY,   32'h0,         3'b111, 3'b000, 32'h0, 1'b1, 1'b0, "t4_idle_data");
        cyc(3'b000, HTRANS_IDLE,   32'h0,         3'b111, 3'b000, 32'h0, 1'b1, 1'b0, "t4_busy_data");
`ifdef AHB_SLAVE_MUX_ERRLOG_EN
        chk("t4_err_valid", 32'(err_valid), 32'd1);
        chk("t4_err_addr_first", err_addr, 32'h4000_0000);
`else
        chk("t4_err_valid", 32'(err_valid), 32'd0);
        chk("t4_err_addr", err_addr, 32'h0);
`endif

        // Clear the log, then an APB slave ERROR passes through and is logged
        err_clr = 1'b1;
        cyc(3'b000, HTRANS_IDLE,   32'h0,         3'b111, 3'b000, 32'h0, 1'b1, 1'b0, "t6_clr");
        err_clr = 1'b0;
        chk("t6_clr_valid", 32'(err_valid), 32'd0);
        chk("t6_clr_addr", err_addr, 32'h0);
        cyc(3'b100, HTRANS_NONSEQ, 32'h3000_0000, 3'b111, 3'b000, 32'h0, 1'b1, 1'b0, "t6_apb_addr");
        cyc(3'b000, HTRANS_IDLE,   32'h0,         3'b011, 3'b100, 32'h3333_3333, 1'b0, 1'b1, "t6_apb_err1");
        cyc(3'b000, HTRANS_IDLE,   32'h0,         3'b111, 3'b100, 32'h3333_3333, 1'b1, 1'b1, "t6_apb_err2");
        cyc(3'b000, HTRANS_IDLE,   32'h0,         3'b111, 3'b000, 32'h0, 1'b1, 1'b0, "t6_apb_done");
`ifdef AHB_SLAVE_MUX_ERRLOG_EN
        chk("t6_apb_err_valid", 32'(err_valid), 32'd1);
        chk("t6_apb_err_addr", err_addr, 32'h3000_0000);
`else
        chk("t6_apb_err_valid", 32'(err_valid), 32'd0);
        chk("t6_apb_err_addr", err_addr, 32'h0);
`endif

        // Reset asserted while the default slave is in ERR1
        cyc(3'b000, HTRANS_NONSEQ, 32'h7000_0000, 3'b111, 3'b000, 32'h0, 1'b1, 1'b0, "t5_addr");
        cyc(3'b000, HTRANS_IDLE,   32'h0,         3'b111, 3'b000, 32'h0, 1'b0, 1'b1, "t5_err1");
        #6;
        hreset = 1'b1;
        #1;
        chk("t5_rst_hready", 32'(hready), 32'd1);
        chk("t5_rst_hresp", 32'(hresp), 32'd0);
        chk("t5_rst_hrdata", hrdata, 32'h0);
        chk("t5_rst_err_valid", 32'(err_valid), 32'd0);
        @(posedge hclk);
        #1;
        hreset = 1'b0;
        cyc(3'b001, HTRANS_NONSEQ, 32'h1000_0020, 3'b111, 3'b000, 32'h0, 1'b1, 1'b0, "t5_post_addr");
        cyc(3'b000, HTRANS_IDLE,   32'h0,         3'b111, 3'b000, 32'hDEAD_BEEF, 1'b1, 1'b0, "t5_post_ram");

        @(posedge hclk);
        @(negedge hclk);
        #1;
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
